// File: rtl/divider_pkg.sv
// Shared constants, state type and helpers for the programmable clock divider.
package divider_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned DIV_MIN   = 2;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    // Length of the posedge-high part of a period (floor of n/2).
    function automatic int unsigned half_of(input int unsigned n);
        return n >> 1;
    endfunction

    // Odd divisors need the extra negedge half-cycle of high time.
    function automatic logic is_odd(input int unsigned n);
        return (n % 2) != 0;
    endfunction

endpackage

// File: rtl/neg_half_stretch.sv
// Negedge flop that extends the high phase by half a cycle for odd divisors.
module neg_half_stretch (
    input  logic clk,
    input  logic rst,
    input  logic odd_en,
    input  logic clk1,
    output logic clk2
);

    // Re-time clk1 onto the falling edge; held low for even divisors.
    always_ff @(negedge clk) begin
        if (rst) begin
            clk2 <= 1'b0;
        end else begin
            clk2 <= odd_en & clk1;
        end
    end

endmodule

// File: rtl/divider_n.sv
// Programmable 50% duty clock divider with boundary-aligned reload and stop.
module divider_n
    import divider_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DIV_INIT = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             div_en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             out_clk,
    output logic             tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             running,
    output logic             cfg_err
);

    run_state_t       state, state_nxt;
    logic [CNT_W-1:0] phase, phase_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] pend, pend_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic             clk1, clk1_nxt;
    logic             clk2;
    logic             tick_nxt;
    logic             err_nxt;
    logic             load_ok;
    logic [CNT_W-1:0] req_div;
    logic [CNT_W-1:0] half;
    logic             rst_q;

    assign half    = CNT_W'(half_of(32'(cur_div)));
    assign running = (state == ST_RUN);
    assign out_clk = clk1 | clk2;

    // Next-state: phase counting, boundary reload, start/stop and error pulse.
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        div_nxt      = cur_div;
        pend_nxt     = pend;
        pend_vld_nxt = pend_vld;
        clk1_nxt     = 1'b0;
        tick_nxt     = 1'b0;
        load_ok      = div_load && (div_val >= CNT_W'(DIV_MIN));
        err_nxt      = div_load && !load_ok;
        req_div      = cur_div;

        if (load_ok) begin
            pend_nxt     = div_val;
            pend_vld_nxt = 1'b1;
        end

        // A load landing on a boundary edge is applied at that same edge.
        if (load_ok) begin
            req_div = div_val;
        end else if (pend_vld) begin
            req_div = pend;
        end

        case (state)
            ST_STOP: begin
                div_nxt      = req_div;
                pend_vld_nxt = 1'b0;
                phase_nxt    = '0;
                if (div_en) begin
                    state_nxt = ST_RUN;
                    tick_nxt  = 1'b1;
                    clk1_nxt  = 1'b1;   // half is at least 1 since N >= 2
                end
            end
            ST_RUN: begin
                if (phase == cur_div - CNT_W'(1)) begin
                    div_nxt      = req_div;
                    pend_vld_nxt = 1'b0;
                    phase_nxt    = '0;
                    if (div_en) begin
                        tick_nxt = 1'b1;
                        clk1_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_STOP;
                    end
                end else begin
                    phase_nxt = phase + CNT_W'(1);
                    clk1_nxt  = (phase_nxt < half);
                end
            end
            default: begin
                state_nxt = ST_STOP;
            end
        endcase
    end

    // Posedge state register with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_STOP;
            phase    <= '0;
            cur_div  <= CNT_W'(DIV_INIT);
            pend     <= '0;
            pend_vld <= 1'b0;
            clk1     <= 1'b0;
            tick     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            cur_div  <= div_nxt;
            pend     <= pend_nxt;
            pend_vld <= pend_vld_nxt;
            clk1     <= clk1_nxt;
            tick     <= tick_nxt;
            cfg_err  <= err_nxt;
        end
    end

    // Carry the posedge-sampled reset to the following negedge.
    always_ff @(posedge sys_clk) begin
        rst_q <= sys_rst;
    end

    neg_half_stretch u_neg_half_stretch (
        .clk    (sys_clk),
        .rst    (rst_q),
        .odd_en (is_odd(32'(cur_div))),
        .clk1   (clk1),
        .clk2   (clk2)
    );

endmodule

// File: tb/tb_divider_n.sv
// Bench for divider_n: directed table, corner sequences and random stimulus.
module tb_divider_n;

    localparam int unsigned DIV_INIT = 5;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       div_en = 1'b0;
    logic       div_load = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       out_clk;
    logic       tick;
    logic [7:0] cur_div;
    logic       running;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    // reference model: period-level view of the divider
    int m_run = 0, m_pos = 0, m_n = DIV_INIT, m_pv = 0, m_pend = 0, m_err = 0, m_tick = 0;

    // sampled DUT outputs of the last step
    logic       s_tick, s_run, s_err, s_op, s_on;
    logic [7:0] s_cur;

    typedef struct {
        logic       rst, en, load;
        logic [7:0] val;
        logic       e_tick, e_run, e_err;
        logic [7:0] e_cur;
        logic       e_op, e_on;
    } vec_t;

    vec_t tbl[16];

    divider_n #(.CNT_W(8), .DIV_INIT(DIV_INIT)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .div_en   (div_en),
        .div_load (div_load),
        .div_val  (div_val),
        .out_clk  (out_clk),
        .tick     (tick),
        .cur_div  (cur_div),
        .running  (running),
        .cfg_err  (cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec rules applied at a posedge: each period is N cycles, boundary applies pending.
    task automatic model_edge();
        if (sys_rst) begin
            m_run = 0; m_pos = 0; m_n = DIV_INIT; m_pv = 0; m_err = 0; m_tick = 0;
        end else begin
            m_err = (div_load && div_val < 2) ? 1 : 0;
            if (div_load && div_val >= 2) begin
                m_pend = int'(div_val);
                m_pv   = 1;
            end
            if (m_run == 0 || m_pos == m_n - 1) begin
                if (m_pv != 0) m_n = m_pend;
                m_pv   = 0;
                m_run  = div_en ? 1 : 0;
                m_pos  = 0;
                m_tick = m_run;
            end else begin
                m_pos++;
                m_tick = 0;
            end
        end
    endtask

    // Out is high for the first N half-cycles of each 2N-half-cycle period.
    function automatic logic exp_out(input int half_idx);
        return (m_run != 0) && (half_idx < m_n);
    endfunction

    task automatic step();
        logic was_rst;
        was_rst = sys_rst;
        @(posedge sys_clk);
        model_edge();
        #1;
        s_tick = tick; s_run = running; s_err = cfg_err; s_cur = cur_div; s_op = out_clk;
        chk("tick", 32'(s_tick), 32'(m_tick));
        chk("cur_div", 32'(s_cur), 32'(m_n));
        chk("running", 32'(s_run), 32'(m_run));
        chk("cfg_err", 32'(s_err), 32'(m_err));
        if (!was_rst) chk("out_pos", 32'(s_op), 32'(exp_out(2 * m_pos)));
        @(negedge sys_clk);
        #1;
        s_on = out_clk;
        chk("out_neg", 32'(s_on), 32'(exp_out(2 * m_pos + 1)));
    endtask

    task automatic drive(input logic rst, input logic en, input logic ld, input logic [7:0] v);
        sys_rst = rst; div_en = en; div_load = ld; div_val = v;
    endtask

    // p < 0 means the terminal phase; n == 0 means any divisor.
    task automatic wait_phase(input int p, input int n, input int limit);
        logic found;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            if (m_run != 0 && (n == 0 || m_n == n) &&
                ((p < 0) ? (m_pos == m_n - 1) : (m_pos == p)))
                found = 1'b1;
            else
                step();
        end
        chk("wait_phase", 32'(found), 32'd1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 8'd5, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1, 8'd5, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 8'd4, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd4, 1'b1, 1'b1};

        // directed table: reset, N=5 waveform, invalid loads, terminal-phase reload to 4
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].val);
            step();
            chk($sformatf("tbl%0d_tick", i), 32'(s_tick), 32'(tbl[i].e_tick));
            chk($sformatf("tbl%0d_run", i), 32'(s_run), 32'(tbl[i].e_run));
            chk($sformatf("tbl%0d_err", i), 32'(s_err), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_cur", i), 32'(s_cur), 32'(tbl[i].e_cur));
            if (!tbl[i].rst) chk($sformatf("tbl%0d_opos", i), 32'(s_op), 32'(tbl[i].e_op));
            chk($sformatf("tbl%0d_oneg", i), 32'(s_on), 32'(tbl[i].e_on));
        end
        drive(1'b0, 1'b1, 1'b0, 8'd0);

        // reload 4 mid-period of a 5-cycle period
        drive(1'b0, 1'b1, 1'b1, 8'd5); step(); drive(1'b0, 1'b1, 1'b0, 8'd0);
        wait_phase(2, 5, 20);
        drive(1'b0, 1'b1, 1'b1, 8'd4); step(); drive(1'b0, 1'b1, 1'b0, 8'd0);
        chk("mid_load_hold", 32'(cur_div), 32'd5);
        for (int i = 0; i < 12; i++) step();

        // stop at phase 1 with N=7, then restart
        drive(1'b0, 1'b1, 1'b1, 8'd7); step(); drive(1'b0, 1'b1, 1'b0, 8'd0);
        wait_phase(1, 7, 30);
        div_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("stop_running", 32'(running), 32'd0);
        chk("stop_out", 32'(out_clk), 32'd0);
        div_en = 1'b1; step();
        chk("restart_out", 32'(out_clk), 32'd1);
        chk("restart_tick", 32'(tick), 32'd1);

        // two loads in one period: last wins
        wait_phase(1, 0, 30);
        drive(1'b0, 1'b1, 1'b1, 8'd9); step();
        drive(1'b0, 1'b1, 1'b0, 8'd0); step();
        drive(1'b0, 1'b1, 1'b1, 8'd6); step();
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        wait_phase(0, 0, 30);
        chk("last_load_wins", 32'(cur_div), 32'd6);
        for (int i = 0; i < 14; i++) step();

        // load and stop on the same boundary edge
        wait_phase(-1, 0, 30);
        drive(1'b0, 1'b0, 1'b1, 8'd3); step(); drive(1'b0, 1'b0, 1'b0, 8'd0);
        chk("simul_cur", 32'(cur_div), 32'd3);
        chk("simul_stop", 32'(running), 32'd0);
        step(); step();
        div_en = 1'b1;

        // reset in the high phase with N=3, then clean restart
        wait_phase(0, 3, 30);
        drive(1'b1, 1'b1, 1'b0, 8'd0); step();
        chk("rst_out_neg", 32'(out_clk), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) step();
        chk("rst_restart_div", 32'(cur_div), 32'(DIV_INIT));

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 7) == 0, 8'($urandom_range(0, 15)));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
